// File: rtl/d_cache_responder_if.sv
// Request/response and memory-port bundle for the data-cache responder.
// Handshake rules: req_* is qualified by req_valid and is held while dc_miss=1;
// mem_req_* is held stable while mem_req_valid=1 until the cycle mem_req_ready=1;
// mem_resp_valid/resp_valid are single-cycle strobes with no back-pressure.
interface d_cache_responder_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ADDR_WIDTH-1:0] req_addr_next;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_data;
    logic                  dc_miss;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [31:0]           mem_req_wdata;
    logic                  mem_resp_valid;
    logic [31:0]           mem_resp_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_addr_next, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output resp_valid, resp_data, dc_miss,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_addr_next, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  resp_valid, resp_data, dc_miss,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
    );
endinterface

// File: rtl/d_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache responder.
// Arrays are indexed by a registered index so a hit answers in the request's own cycle.
module d_cache_responder #(
    parameter int INDEX_WIDTH = 4,
    parameter int LINE_WORDS  = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    d_cache_responder_if.slave    bus,
    output logic [2:0]            o_dbg_state
);
    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int LINES   = 1 << INDEX_WIDTH;
    localparam int IDX_LSB = OFF_W + 2;
    localparam int TAG_LSB = IDX_LSB + INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(LINE_WORDS - 1);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_REFILL_REQ  = 3'd1;
    localparam logic [2:0] S_REFILL_DATA = 3'd2;
    localparam logic [2:0] S_WRITE_THRU  = 3'd3;
    localparam logic [2:0] S_DONE        = 3'd4;

    logic [2:0]             r_state;
    logic [OFF_W-1:0]       r_cnt;
    logic [INDEX_WIDTH-1:0] r_rd_index;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [31:0]            r_data [LINES*LINE_WORDS];

    logic [OFF_W-1:0]       w_cur_off;
    logic [INDEX_WIDTH-1:0] w_cur_index;
    logic [TAG_W-1:0]       w_cur_tag;
    logic [INDEX_WIDTH-1:0] w_next_index;
    logic [ADDR_WIDTH-1:0]  w_line_base;
    logic                   w_rd_valid;
    logic [TAG_W-1:0]       w_rd_tag;
    logic [31:0]            w_rd_word;
    logic                   w_idx_ok;
    logic                   w_hit;
    logic                   w_last_word;
    logic                   w_unused;

    logic                   w_resp_valid;
    logic [31:0]            w_resp_data;
    logic                   w_dc_miss;
    logic                   w_mem_req_valid;
    logic                   w_mem_req_write;
    logic [ADDR_WIDTH-1:0]  w_mem_req_addr;
    logic [31:0]            w_mem_req_wdata;

    assign w_cur_off    = bus.req_addr[IDX_LSB-1:2];
    assign w_cur_index  = bus.req_addr[TAG_LSB-1:IDX_LSB];
    assign w_cur_tag    = bus.req_addr[ADDR_WIDTH-1:TAG_LSB];
    assign w_next_index = bus.req_addr_next[TAG_LSB-1:IDX_LSB];
    assign w_line_base  = {bus.req_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};

    assign w_rd_valid = r_valid[r_rd_index];
    assign w_rd_tag   = r_tag[r_rd_index];
    assign w_rd_word  = r_data[{r_rd_index, w_cur_off}];

    // A stale pre-read index (addr_next did not predict req_addr) is a one-cycle replay.
    assign w_idx_ok    = (r_rd_index == w_cur_index);
    assign w_hit       = w_idx_ok && w_rd_valid && (w_rd_tag == w_cur_tag);
    assign w_last_word = (r_cnt == LAST_CNT);

    assign w_unused = ^{bus.req_addr[1:0], bus.req_addr_next[ADDR_WIDTH-1:TAG_LSB],
                        bus.req_addr_next[IDX_LSB-1:0]};

    always_comb begin
        w_resp_valid    = 1'b0;
        w_resp_data     = 32'h0;
        w_dc_miss       = 1'b0;
        w_mem_req_valid = 1'b0;
        w_mem_req_write = 1'b0;
        w_mem_req_addr  = '0;
        w_mem_req_wdata = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!bus.req_write && w_hit) begin
                        w_resp_valid = 1'b1;
                        w_resp_data  = w_rd_word;
                    end else begin
                        w_dc_miss = 1'b1;
                    end
                end
            end
            S_REFILL_REQ: begin
                w_dc_miss       = 1'b1;
                w_mem_req_valid = 1'b1;
                w_mem_req_addr  = w_line_base;
            end
            S_REFILL_DATA: begin
                w_dc_miss = 1'b1;
            end
            S_WRITE_THRU: begin
                w_dc_miss       = 1'b1;
                w_mem_req_valid = 1'b1;
                w_mem_req_write = 1'b1;
                w_mem_req_addr  = bus.req_addr;
                w_mem_req_wdata = bus.req_wdata;
            end
            default: begin
                w_dc_miss = 1'b0;
            end
        endcase
        // Outputs read as zero for as long as reset is applied.
        if (rst) begin
            w_resp_valid    = 1'b0;
            w_resp_data     = 32'h0;
            w_dc_miss       = 1'b0;
            w_mem_req_valid = 1'b0;
            w_mem_req_write = 1'b0;
            w_mem_req_addr  = '0;
            w_mem_req_wdata = 32'h0;
        end
    end

    assign bus.resp_valid    = w_resp_valid;
    assign bus.resp_data     = w_resp_data;
    assign bus.dc_miss       = w_dc_miss;
    assign bus.mem_req_valid = w_mem_req_valid;
    assign bus.mem_req_write = w_mem_req_write;
    assign bus.mem_req_addr  = w_mem_req_addr;
    assign bus.mem_req_wdata = w_mem_req_wdata;
    assign o_dbg_state       = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd_index <= '0;
            r_valid    <= '0;
        end else begin
            r_rd_index <= w_dc_miss ? w_cur_index : w_next_index;
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid && w_idx_ok) begin
                        if (bus.req_write) begin
                            r_state <= S_WRITE_THRU;
                        end else if (!w_hit) begin
                            // Invalidate up front so an aborted refill never leaves a mixed line.
                            r_valid[w_cur_index] <= 1'b0;
                            r_state              <= S_REFILL_REQ;
                        end
                    end
                end
                S_REFILL_REQ: begin
                    r_cnt <= '0;
                    if (bus.mem_req_ready) begin
                        r_state <= S_REFILL_DATA;
                    end
                end
                S_REFILL_DATA: begin
                    if (bus.mem_resp_valid) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_word) begin
                            r_valid[w_cur_index] <= 1'b1;
                            r_state              <= S_IDLE;
                        end
                    end
                end
                S_WRITE_THRU: begin
                    if (bus.mem_req_ready) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.req_valid && bus.req_write && w_hit) begin
            r_data[{w_cur_index, w_cur_off}] <= bus.req_wdata;
        end
        if (r_state == S_REFILL_DATA && bus.mem_resp_valid) begin
            r_data[{w_cur_index, r_cnt}] <= bus.mem_resp_data;
            if (w_last_word) begin
                r_tag[w_cur_index] <= w_cur_tag;
            end
        end
    end
endmodule

// File: tb/tb_d_cache_responder.sv
// Randomised bench for d_cache_responder against a line-level cache and memory model.
module tb_d_cache_responder;
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;

    d_cache_responder_if #(.ADDR_WIDTH(32)) bus ();

    d_cache_responder #(
        .INDEX_WIDTH(4),
        .LINE_WORDS (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_dbg_state(dbg_state)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          gap;
    } req_t;

    int          n_checks = 0;
    int          n_errors = 0;
    req_t        seq[$];
    logic        m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] mem     [logic [29:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return 32'h5EED_0000 ^ (a * 32'h9E37_79B9);
    endfunction

    function automatic logic [3:0] idx_of(input logic [31:0] a);
        return a[7:4];
    endfunction

    function automatic logic [23:0] tag_of(input logic [31:0] a);
        return a[31:8];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b0;
    endtask

    task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d, input int gap);
        req_t r;
        r.w = w; r.a = a; r.d = d; r.gap = gap;
        seq.push_back(r);
    endtask

    task automatic idle(input logic [31:0] nxt);
        bus.req_valid     = 1'b0;
        bus.req_addr_next = nxt;
        @(negedge clk);
        check("idle_miss", bus.dc_miss, 1'b0);
        check("idle_rv", bus.resp_valid, 1'b0);
        step();
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] nxt, input int gap_in);
        logic        hit;
        int          gap;
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        hit  = m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
        gap  = (gap_in < 0) ? int'($urandom_range(0, 3)) : gap_in;
        bus.req_valid     = 1'b1;
        bus.req_write     = w;
        bus.req_addr      = a;
        bus.req_wdata     = d;
        bus.req_addr_next = nxt;
        if (!w && hit) begin
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_data  = $urandom;
            @(negedge clk);
            check("hit_miss", bus.dc_miss, 1'b0);
            check("hit_rv", bus.resp_valid, 1'b1);
            check("hit_data", bus.resp_data, mem_rd(a));
            check("hit_mreq", bus.mem_req_valid, 1'b0);
            step();
        end else begin
            @(negedge clk);
            check("req_miss", bus.dc_miss, 1'b1);
            check("req_rv", bus.resp_valid, 1'b0);
            step();
            for (int i = 0; i <= gap; i++) begin
                bus.mem_req_ready  = (i == gap);
                bus.mem_resp_valid = 1'($urandom_range(0, 1));
                bus.mem_resp_data  = $urandom;
                @(negedge clk);
                check("mreq_valid", bus.mem_req_valid, 1'b1);
                check("mreq_write", bus.mem_req_write, w);
                check("mreq_addr", bus.mem_req_addr, w ? a : base);
                if (w) check("mreq_wdata", bus.mem_req_wdata, d);
                check("mreq_stall", bus.dc_miss, 1'b1);
                step();
            end
            if (w) begin
                mem[a[31:2]] = d;
                @(negedge clk);
                check("done_miss", bus.dc_miss, 1'b0);
                check("done_rv", bus.resp_valid, 1'b0);
                check("done_mreq", bus.mem_req_valid, 1'b0);
                step();
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int wgap;
                    wgap = $urandom_range(0, 2);
                    for (int i = 0; i <= wgap; i++) begin
                        bus.mem_resp_valid = (i == wgap);
                        bus.mem_resp_data  = (i == wgap) ? mem_rd(base + 32'(4 * k)) : $urandom;
                        @(negedge clk);
                        check("fill_stall", bus.dc_miss, 1'b1);
                        check("fill_mreq", bus.mem_req_valid, 1'b0);
                        step();
                    end
                end
                m_valid[idx_of(a)] = 1'b1;
                m_tag[idx_of(a)]   = tag_of(a);
                @(negedge clk);
                check("replay_miss", bus.dc_miss, 1'b0);
                check("replay_rv", bus.resp_valid, 1'b1);
                check("replay_data", bus.resp_data, mem_rd(a));
                step();
            end
        end
    endtask

    task automatic run_seq();
        idle(seq[0].a);
        for (int i = 0; i < seq.size(); i++) begin
            do_req(seq[i].w, seq[i].a, seq[i].d,
                   (i + 1 < seq.size()) ? seq[i+1].a : seq[i].a, seq[i].gap);
        end
        bus.req_valid = 1'b0;
        seq.delete();
    endtask

    // Starts a refill of a line known to miss, then resets after two words.
    task automatic reset_during_refill(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        bus.req_valid     = 1'b1;
        bus.req_write     = 1'b0;
        bus.req_addr      = a;
        bus.req_addr_next = a;
        @(negedge clk);
        check("rst_req_miss", bus.dc_miss, 1'b1);
        step();
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        check("rst_mreq_addr", bus.mem_req_addr, base);
        step();
        for (int k = 0; k < 2; k++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = mem_rd(base + 32'(4 * k));
            @(negedge clk);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_dc_miss", bus.dc_miss, 1'b0);
        check("rst_rv", bus.resp_valid, 1'b0);
        check("rst_mreq", bus.mem_req_valid, 1'b0);
        check("rst_state", dbg_state, 3'd0);
        step();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_addr       = 32'h0;
        bus.req_addr_next  = 32'h0;
        bus.req_wdata      = 32'h0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 24'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dc_miss", bus.dc_miss, 1'b0);
        check("reset_rv", bus.resp_valid, 1'b0);
        check("reset_mreq", bus.mem_req_valid, 1'b0);
        check("reset_state", dbg_state, 3'd0);
        step();
        rst = 1'b0;

        add(1'b0, 32'h100, 32'h0, -1);
        add(1'b0, 32'h10C, 32'h0, -1);
        add(1'b1, 32'h104, 32'hDEAD, 3);
        add(1'b0, 32'h104, 32'h0, -1);
        add(1'b0, 32'h500, 32'h0, -1);
        add(1'b0, 32'h100, 32'h0, -1);
        run_seq();

        reset_during_refill(32'h500);

        add(1'b0, 32'h100, 32'h0, -1);
        add(1'b0, 32'h100, 32'h0, -1);
        add(1'b0, 32'h104, 32'h0, -1);
        add(1'b0, 32'h108, 32'h0, -1);
        run_seq();

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = {22'h0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), 2'b00};
            add(($urandom_range(0, 9) < 3), a, $urandom, -1);
        end
        run_seq();

        idle(32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end
endmodule
